// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment display scanner.
//   A prescaler divides clk into digit slots of SCAN_DIV cycles, and a digit
//   index walks all digits once per frame. Within each slot the digit is lit
//   for a brightness-dependent number of cycles. The last cycle of every slot
//   is always dark so that no digit ghosts into its neighbour.
//   The display inputs are snapshotted once per frame, in the frame_done
//   cycle, so every frame is drawn from one consistent set of values.
//
// Optional feature: define SEG_LZB_EN to blank leading zero digits. Digit 0
//   is never blanked. Without the macro, every enabled digit is shown.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   data       hex nibble per digit; nibble i = data[4i+3:4i], digit 0 rightmost
//   dp         decimal point per digit, 1 = lit
//   digit_en   per-digit enable, 0 = dark
//   bright     brightness 0..15 (15 = whole slot lit except the guard cycle)
//   SEG        active-low cathodes, SEG[6:0] = g..a, SEG[7] = dp
//   AN         active-low anodes, at most one bit low
//   frame_done one-cycle pulse in the last cycle of each frame
module seg_scan_ctrl #(
   parameter int NUM_DIGITS = 8,
   parameter int SCAN_DIV   = 100000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] data,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic [3:0]              bright,
   output logic [7:0]              SEG,
   output logic [NUM_DIGITS-1:0]   AN,
   output logic                    frame_done
);

   localparam int PW = $clog2(SCAN_DIV + 1);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

   logic [PW-1:0]           pcnt;
   logic [IW-1:0]           idx;
   logic [4*NUM_DIGITS-1:0] data_sh;
   logic [NUM_DIGITS-1:0]   dp_sh;
   logic [NUM_DIGITS-1:0]   en_sh;
   logic [3:0]              bright_sh;
   logic [PW-1:0]           on_thresh;

   logic                    pcnt_last;
   logic                    idx_last;
   logic [31:0]             thr_full;
   logic [NUM_DIGITS-1:0]   blank;
   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    cur_en;
   logic                    cur_blank;
   logic [NUM_DIGITS-1:0]   an_sel;
   logic                    lit;
   logic [6:0]              seg_dec;

   assign pcnt_last  = (pcnt == P_LAST);
   assign idx_last   = (idx == I_LAST);
   assign frame_done = pcnt_last && idx_last;

   // Lit window for the next frame, from the brightness value being captured.
   assign thr_full = ((32'(bright) + 32'd1) * 32'(SCAN_DIV)) >> 4;

`ifdef SEG_LZB_EN
   logic zero_above;

   // Walk from the most significant digit down; a digit is blanked while it
   // and everything above it is zero.
   always_comb begin
      blank      = '0;
      zero_above = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_above = zero_above && (data_sh[4*i +: 4] == 4'h0);
         blank[i]   = zero_above;
      end
   end
`else
   assign blank = '0;
`endif

   always_comb begin
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_en    = 1'b0;
      cur_blank = 1'b0;
      an_sel    = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IW'(i)) begin
            cur_nib   = data_sh[4*i +: 4];
            cur_dp    = dp_sh[i];
            cur_en    = en_sh[i];
            cur_blank = blank[i];
            an_sel[i] = 1'b0;
         end
      end
   end

   // Last cycle of every slot is forced dark as an inter-digit guard.
   assign lit = cur_en && !cur_blank && (pcnt < on_thresh) && !pcnt_last;

   always_comb begin
      seg_dec = 7'h7F;
      case (cur_nib)
         4'h0: seg_dec = 7'h40;
         4'h1: seg_dec = 7'h79;
         4'h2: seg_dec = 7'h24;
         4'h3: seg_dec = 7'h30;
         4'h4: seg_dec = 7'h19;
         4'h5: seg_dec = 7'h12;
         4'h6: seg_dec = 7'h02;
         4'h7: seg_dec = 7'h78;
         4'h8: seg_dec = 7'h00;
         4'h9: seg_dec = 7'h10;
         4'hA: seg_dec = 7'h08;
         4'hB: seg_dec = 7'h03;
         4'hC: seg_dec = 7'h46;
         4'hD: seg_dec = 7'h21;
         4'hE: seg_dec = 7'h06;
         4'hF: seg_dec = 7'h0E;
         default: seg_dec = 7'h7F;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt      <= '0;
         idx       <= '0;
         data_sh   <= '0;
         dp_sh     <= '0;
         en_sh     <= '0;
         bright_sh <= '0;
         on_thresh <= '0;
         AN        <= '1;
         SEG       <= 8'hFF;
      end else begin
         if (pcnt_last) begin
            pcnt <= '0;
            idx  <= idx_last ? '0 : idx + 1'b1;
         end else begin
            pcnt <= pcnt + 1'b1;
         end

         if (frame_done) begin
            data_sh   <= data;
            dp_sh     <= dp;
            en_sh     <= digit_en;
            bright_sh <= bright;
            on_thresh <= thr_full[PW-1:0];
         end

         if (lit) begin
            AN  <= an_sel;
            SEG <= {~cur_dp, seg_dec};
         end else begin
            AN  <= '1;
            SEG <= 8'hFF;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

   logic        clk;
   logic        rst;
   logic [31:0] data;
   logic [7:0]  dp;
   logic [7:0]  digit_en;
   logic [3:0]  bright;
   logic [7:0]  SEG;
   logic [7:0]  AN;
   logic        frame_done;

   int vec_cnt  = 0;
   int miss_cnt = 0;
   int k        = 0;

   seg_scan_ctrl #(.NUM_DIGITS(8), .SCAN_DIV(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .data       (data),
      .dp         (dp),
      .digit_en   (digit_en),
      .bright     (bright),
      .SEG        (SEG),
      .AN         (AN),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp)
      else begin
         miss_cnt++;
         $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
      end
   endtask

   // k counts rising edges since the last reset release; sampling is on negedge.
   task automatic goto(input int target);
      while (k < target) begin
         @(negedge clk);
         k++;
      end
   endtask

   initial begin
      rst      = 1'b1;
      data     = 32'h0;
      dp       = 8'h00;
      digit_en = 8'h00;
      bright   = 4'd0;
      repeat (3) @(negedge clk);
      chk("rst_an", AN, 8'hFF);
      chk("rst_seg", SEG, 8'hFF);
      chk("rst_fd", frame_done, 1'b0);

      data     = 32'h1234ABCD;
      dp       = 8'h00;
      digit_en = 8'hFF;
      bright   = 4'd15;
      rst      = 1'b0;
      k        = 0;

      // Frame 1 is dark: shadows were cleared by reset.
      for (int t = 1; t <= 128; t++) begin
         goto(t);
         chk("f1_dark_an", AN, 8'hFF);
      end
      goto(126); // already past; kept implicit
      // frame_done pulse at the end of frame 1 was at k=127
      k = k; // no-op for clarity of the linear sequence
      chk("f1_dark_seg", SEG, 8'hFF);

      goto(129);
      chk("f2_s0_an", AN, 8'hFE);
      chk("f2_s0_seg", SEG, 8'hA1);
      goto(143);
      chk("f2_s0_late_an", AN, 8'hFE);
      goto(144);
      chk("f2_guard_an", AN, 8'hFF);
      goto(145);
      chk("f2_s1_an", AN, 8'hFD);
      chk("f2_s1_seg", SEG, 8'hC6);
      bright = 4'd3;
      goto(241);
      chk("f2_s7_an", AN, 8'h7F);
      chk("f2_s7_seg", SEG, 8'hF9);
      goto(254);
      chk("fd_254", frame_done, 1'b0);
      goto(255);
      chk("fd_255", frame_done, 1'b1);
      goto(256);
      chk("fd_256", frame_done, 1'b0);
      chk("f2_end_an", AN, 8'hFF);

      // Frame 3, bright = 3: 4 lit cycles then 12 dark in each slot.
      for (int t = 257; t <= 272; t++) begin
         goto(t);
         chk("b3_an", AN, (t <= 260) ? 32'hFE : 32'hFF);
      end
      goto(273);
      chk("b3_s1_an", AN, 8'hFD);
      chk("b3_s1_seg", SEG, 8'hC6);

      // Change inputs in slot 3; frame 3 keeps showing the old snapshot.
      goto(304);
      data = 32'h87654321;
      dp   = 8'h01;
      goto(321);
      chk("f3_s4_an", AN, 8'hEF);
      chk("f3_s4_seg", SEG, 8'h99);
      goto(383);
      chk("fd_383", frame_done, 1'b1);
      goto(385);
      chk("f4_s0_an", AN, 8'hFE);
      chk("f4_s0_seg", SEG, 8'h79);
      goto(466);
      chk("f4_s5_an", AN, 8'hDF);
      chk("f4_s5_seg", SEG, 8'h82);

      // Asynchronous reset in the middle of a lit slot.
      rst = 1'b1;
      #1;
      chk("arst_an", AN, 8'hFF);
      chk("arst_seg", SEG, 8'hFF);
      chk("arst_fd", frame_done, 1'b0);
      repeat (2) @(negedge clk);
      chk("arst_hold_an", AN, 8'hFF);

      data     = 32'h000000A0;
      dp       = 8'h00;
      bright   = 4'd15;
      digit_en = 8'hFF;
      rst      = 1'b0;
      k        = 0;
      goto(1);
      chk("r2_dark_k1", AN, 8'hFF);
      goto(17);
      chk("r2_dark_k17", AN, 8'hFF);
      goto(127);
      chk("r2_fd_127", frame_done, 1'b1);
      goto(128);
      chk("r2_fd_128", frame_done, 1'b0);
      goto(129);
      chk("lz_d0_an", AN, 8'hFE);
      chk("lz_d0_seg", SEG, 8'hC0);
      goto(145);
      chk("lz_d1_an", AN, 8'hFD);
      chk("lz_d1_seg", SEG, 8'h88);
      goto(161);
`ifdef SEG_LZB_EN
      chk("lz_d2_an", AN, 8'hFF);
      chk("lz_d2_seg", SEG, 8'hFF);
`else
      chk("lz_d2_an", AN, 8'hFB);
      chk("lz_d2_seg", SEG, 8'hC0);
`endif
      goto(241);
`ifdef SEG_LZB_EN
      chk("lz_d7_an", AN, 8'hFF);
      chk("lz_d7_seg", SEG, 8'hFF);
`else
      chk("lz_d7_an", AN, 8'h7F);
      chk("lz_d7_seg", SEG, 8'hC0);
`endif
      goto(254);
      chk("r2_fd_254", frame_done, 1'b0);
      goto(255);
      chk("r2_fd_255", frame_done, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, giving the number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 100000, giving clk cycles per digit slot (legal >= 16).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port data, input, 4*NUM_DIGITS bits: hex nibble per digit; nibble i is data[4i+3:4i]; digit 0 is rightmost.
REQ-006 SHALL have port dp, input, NUM_DIGITS bits: decimal point request per digit, 1 = lit.
REQ-007 SHALL have port digit_en, input, NUM_DIGITS bits: per-digit enable; 0 = digit dark.
REQ-008 SHALL have port bright, input, 4 bits: brightness level 0..15.
REQ-009 SHALL have port SEG, output, 8 bits: active-low cathodes; SEG[6:0] = g..a, SEG[7] = dp.
REQ-010 SHALL have port AN, output, NUM_DIGITS bits: active-low anodes, at most one bit low.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse at end of each full scan frame.

Function
REQ-012 SHALL run prescaler pcnt 0..SCAN_DIV-1, wrapping to 0, incrementing every cycle.
REQ-013 SHALL advance digit index idx when pcnt = SCAN_DIV-1; idx wraps from NUM_DIGITS-1 to 0.
REQ-014 SHALL assert frame_done for exactly the cycle in which pcnt = SCAN_DIV-1 and idx = NUM_DIGITS-1.
REQ-015 SHALL capture data, dp, digit_en and bright into shadow registers in the frame_done cycle; inputs changing mid-frame SHALL NOT affect the frame in progress.
REQ-016 SHALL compute on_thresh = ((bright_shadow+1)*SCAN_DIV)>>4 at shadow load; bright = 15 SHALL give a fully lit slot.
REQ-017 SHALL light the current digit only while pcnt < on_thresh, digit_en_shadow[idx] = 1 and the digit is not blanked per REQ-023.
REQ-018 When lit: AN SHALL be all-ones except bit idx = 0; SEG[6:0] SHALL be active-low standard hex decode of nibble idx (0 -> 7'h40, 8 -> 7'h00, D -> 7'h21, F -> 7'h0E); SEG[7] = ~dp_shadow[idx].
REQ-019 When dark: AN SHALL be all-ones and SEG SHALL be 8'hFF.
REQ-020 AN and SEG SHALL be registered, reflecting pcnt/idx/shadow state with exactly one cycle latency; no combinational path from any input to outputs.
REQ-021 AN SHALL go all-ones for at least one cycle between consecutive lit digits (no ghosting): digit dark when pcnt = SCAN_DIV-1.

Reset
REQ-022 While rst is high, and immediately on its assertion (also mid-frame): pcnt = 0, idx = 0, all shadows = 0, AN = all-ones, SEG = 8'hFF, frame_done = 0; first frame after release SHALL be fully dark (digit_en_shadow = 0).

Configuration
REQ-023 With macro SEG_LZB_EN defined: digit i (i >= 1) SHALL be blanked when nibble i and every higher nibble of data_shadow are zero; digit 0 never blanked; a blanked digit is fully dark including dp. Without SEG_LZB_EN: no leading-zero blanking; all enabled digits display.

Verification (NUM_DIGITS = 8, SCAN_DIV = 16)
REQ-024 Hold data = 32'h1234ABCD, dp = 0, digit_en = 8'hFF, bright = 15 for two frames -> in frame 2, slot 0: AN = 8'hFE, SEG = 8'hA1; slot 7: AN = 8'h7F, SEG = 8'hF9; frame 1 fully dark.
REQ-025 Free run -> frame_done pulses exactly once every 128 cycles, coincident with idx 7 -> 0 wrap.
REQ-026 bright = 3 -> each lit slot shows AN low for exactly 4 cycles, then AN = 8'hFF for 12 cycles.
REQ-027 SEG_LZB_EN defined, data = 32'h000000A0, digit_en = 8'hFF -> digits 2..7 never drive AN low; digit 1 SEG = 8'h88, digit 0 SEG = 8'hC0; without macro digits 2..7 show 8'hC0.
REQ-028 Change data at slot 3 of a frame -> displayed values unchanged until slot 0 of next frame; assert rst at slot 5 -> AN = 8'hFF, SEG = 8'hFF, frame_done = 0 without waiting for clk edge.
